fifo_flagged: RTL and testbench
===============================

Name: fifo_flagged

Overview:
Parametrised synchronous FIFO and the successor to the existing fixed FIFO.
- Supports any depth of 2 or more, not just powers of two.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Defines read/write-at-boundary behaviour explicitly.
- Used as the generic buffering element between streaming stages in one clock domain.

Parameters:
- DataWidth, 32, width of each data word.
- Depth, 8, number of entries; must be 2 or more; need not be a power of two.
- AfThresh, 6, almostFull asserts when count >= AfThresh; legal range 1..Depth.
- AeThresh, 2, almostEmpty asserts when count <= AeThresh; legal range 0..Depth-1, and AeThresh < AfThresh.
- PtrWidth, $clog2(Depth), derived localparam, width of the read and write pointers.
- CntWidth, $clog2(Depth+1), derived localparam, width of count.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- writeEn  in  1  write request.
- writeData  in  DataWidth  write data.
- readEn  in  1  read request (pop).
- readData  out  DataWidth  read data.
- readValid  out  1  readData holds a newly popped word.
- full  out  1  count == Depth.
- empty  out  1  count == 0.
- almostFull  out  1  count >= AfThresh.
- almostEmpty  out  1  count <= AeThresh.
- count  out  CntWidth  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clearErr  in  1  clears overflow and underflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wrPtr=0, rdPtr=0, count=0.
  - empty=1, full=0, almostEmpty=1, almostFull=0.
  - overflow=0, underflow=0, readValid=0, readData=0.
  - Memory contents are not reset.
- Accept rules:
  - rdAcc = readEn && !empty.
  - wrAcc = writeEn && (!full || rdAcc).
  - When full, a simultaneous read and write are both accepted and count stays Depth.
  - When empty, a simultaneous read and write: the read is rejected (no bypass), the write is accepted, and underflow sets.
- Pointers:
  - On wrAcc: mem[wrPtr] <= writeData; wrPtr advances.
  - On rdAcc: rdPtr advances.
  - Wrap is explicit: when a pointer equals Depth-1 it goes to 0 on its next advance. Legal for non-power-of-two Depth.
- Count:
  - count_next = count + wrAcc - rdAcc.
  - count is unsigned CntWidth; it never exceeds Depth and never underflows.
- Flags:
  - All status flags are registered and computed from count_next, so they are cycle-aligned with count.
  - There is no combinational path from inputs to any flag.
- Errors:
  - overflow sets on (writeEn && !wrAcc).
  - underflow sets on (readEn && !rdAcc).
  - Both hold until clearErr.
  - If clearErr and a new error event occur in the same cycle, the set wins.
  - Rejected operations do not modify pointers, count or memory.
- Read data, standard mode:
  - On rdAcc, readData <= mem[rdPtr] at the next edge; readValid pulses high for exactly that one cycle. Read latency is 1 cycle.
  - readData holds its value when there is no rdAcc.
- Mid-operation reset: any in-flight read is dropped, readValid returns to 0, and all pointers, count, flags and error bits return to their reset values.

Optional Feature:
- Macro: FIFO_FLAGGED_FWFT_EN.
- Defined (first-word-fall-through):
  - readData = mem[rdPtr] continuously.
  - readValid = !empty.
  - readEn acts as an acknowledge: on rdAcc, the next word is presented the following cycle.
  - A write into an empty FIFO appears on readData, with readValid=1, one cycle after the write edge.
- Undefined: standard registered read with 1-cycle latency, as described above.
- Accept rules, count, flags and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg:
  - ptr_wrap function (increment with wrap at Depth-1).
  - Width helper functions for PtrWidth and CntWidth.
  - Typedef fifo_err_t, a packed struct {overflow, underflow}.
- Sub-module fifo_mem:
  - Simple dual-port RAM, DataWidth x Depth.
  - Synchronous write port and asynchronous read port.
  - The registered readData stage lives in fifo_flagged, so fifo_mem is shared by both modes.

Test Plan:
1. Depth=8, AfThresh=6, AeThresh=2; release reset; write 0x11..0x18 on consecutive cycles -> full rises the cycle after the 8th write; almostFull rises after the 6th; almostEmpty falls after the 3rd; count=8. Pop all 8 -> data returns 0x11..0x18 in order, readValid on each.
2. Full FIFO, one cycle with writeEn=1 and readEn=1, writeData=0xAA -> count stays 8, full stays 1, overflow=0; 0xAA is read out last.
3. Full FIFO, writeEn=1 only -> overflow=1, count=8, contents unchanged. Pulse clearErr in the same cycle as another rejected write -> overflow stays 1. Pulse clearErr alone -> overflow=0.
4. Empty FIFO, readEn=1 and writeEn=1, writeData=0x5 -> underflow=1, count=1, no readValid pulse; the next pop returns 0x5.
5. Depth=5: 12 write/pop pairs with data 0..11 -> pointers wrap 4->0 correctly and all data matches. Assert rst_n low mid-sequence -> count=0, empty=1, readValid=0 immediately.
6. FIFO_FLAGGED_FWFT_EN defined: write 0x77 into empty -> next cycle readValid=1 and readData=0x77 with no readEn; pop -> readValid=0 the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged FIFO: pointer wrap, width helpers, error struct.
package fifo_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap keeps non-power-of-two depths legal.
  function automatic int ptr_wrap(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 8,
  localparam int PtrWidth = ptr_width(Depth)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PtrWidth-1:0]  wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [PtrWidth-1:0]  rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_flagged.sv
// Parametrised synchronous FIFO with count, almost flags and sticky error flags.
// Define FIFO_FLAGGED_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle reads.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 8,
  parameter int AfThresh  = 6,
  parameter int AeThresh  = 2,
  localparam int PtrWidth = ptr_width(Depth),
  localparam int CntWidth = cnt_width(Depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 writeEn,
  input  logic [DataWidth-1:0] writeData,
  input  logic                 readEn,
  output logic [DataWidth-1:0] readData,
  output logic                 readValid,
  output logic                 full,
  output logic                 empty,
  output logic                 almostFull,
  output logic                 almostEmpty,
  output logic [CntWidth-1:0]  count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clearErr
);

  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [CntWidth-1:0]  count_next;
  logic [DataWidth-1:0] mem_rdata;
  logic                 rd_acc;
  logic                 wr_acc;
  fifo_err_t            err_q;
  fifo_err_t            err_next;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = readEn && !empty;
  assign wr_acc = writeEn && (!full || rd_acc);

  fifo_mem #(
    .DataWidth(DataWidth),
    .Depth    (Depth)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(writeData),
    .rd_addr(rd_ptr),
    .rd_data(mem_rdata)
  );

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc) begin
      count_next = count + CntWidth'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CntWidth'(1);
    end
  end

  // New error events override a same-cycle clear.
  always_comb begin
    err_next = clearErr ? '0 : err_q;
    if (writeEn && !wr_acc) begin
      err_next.overflow = 1'b1;
    end
    if (readEn && !rd_acc) begin
      err_next.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
      err_q       <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= PtrWidth'(ptr_wrap(int'(wr_ptr), Depth));
      end
      if (rd_acc) begin
        rd_ptr <= PtrWidth'(ptr_wrap(int'(rd_ptr), Depth));
      end
      count       <= count_next;
      full        <= (count_next == CntWidth'(Depth));
      empty       <= (count_next == '0);
      almostFull  <= (count_next >= CntWidth'(AfThresh));
      almostEmpty <= (count_next <= CntWidth'(AeThresh));
      err_q       <= err_next;
    end
  end

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

`ifdef FIFO_FLAGGED_FWFT_EN
  assign readData  = mem_rdata;
  assign readValid = !empty;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readData  <= '0;
      readValid <= 1'b0;
    end else begin
      readValid <= rd_acc;
      if (rd_acc) begin
        readData <= mem_rdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_flagged.sv
// Self-checking bench: drives one stimulus stream into a Depth=8 and a Depth=5 FIFO,
// each compared against its own queue-style reference model.
module tb_fifo_flagged;

  localparam int DW  = 32;
  localparam int DA  = 8;
  localparam int AFA = 6;
  localparam int AEA = 2;
  localparam int DB  = 5;
  localparam int AFB = 4;
  localparam int AEB = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          writeEn = 1'b0;
  logic          readEn = 1'b0;
  logic          clearErr = 1'b0;
  logic [DW-1:0] writeData = '0;

  logic [DW-1:0] rdA, rdB;
  logic          rvA, fullA, emptyA, afA, aeA, ovA, unA;
  logic          rvB, fullB, emptyB, afB, aeB, ovB, unB;
  logic [3:0]    cntA;
  logic [2:0]    cntB;

  int compared = 0;
  int mismatched = 0;

  int            depthM [2];
  int            afM    [2];
  int            aeM    [2];
  logic [31:0]   store  [2][8];
  int            head   [2];
  int            cnt    [2];
  bit            ovM    [2];
  bit            unM    [2];
  bit            rvM    [2];
  logic [31:0]   rdM    [2];

  always #5 clk = ~clk;

  fifo_flagged #(.DataWidth(DW), .Depth(DA), .AfThresh(AFA), .AeThresh(AEA)) dutA (
    .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .writeData(writeData), .readEn(readEn),
    .readData(rdA), .readValid(rvA), .full(fullA), .empty(emptyA), .almostFull(afA),
    .almostEmpty(aeA), .count(cntA), .overflow(ovA), .underflow(unA), .clearErr(clearErr)
  );

  fifo_flagged #(.DataWidth(DW), .Depth(DB), .AfThresh(AFB), .AeThresh(AEB)) dutB (
    .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .writeData(writeData), .readEn(readEn),
    .readData(rdB), .readValid(rvB), .full(fullB), .empty(emptyB), .almostFull(afB),
    .almostEmpty(aeB), .count(cntB), .overflow(ovB), .underflow(unB), .clearErr(clearErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
      ovM[i]  = 1'b0;
      unM[i]  = 1'b0;
      rvM[i]  = 1'b0;
      rdM[i]  = '0;
    end
  endtask

  // Occupancy-level rules: pop from the front, push at the back, errors are sticky.
  task automatic modelStep(input bit we, input logic [31:0] wd, input bit re, input bit ce);
    for (int i = 0; i < 2; i++) begin
      bit rAcc;
      bit wAcc;
      rAcc = re && (cnt[i] > 0);
      wAcc = we && ((cnt[i] < depthM[i]) || rAcc);
      rvM[i] = rAcc;
      if (rAcc) begin
        rdM[i]  = store[i][head[i]];
        head[i] = (head[i] + 1) % depthM[i];
        cnt[i]  = cnt[i] - 1;
      end
      if (wAcc) begin
        store[i][(head[i] + cnt[i]) % depthM[i]] = wd;
        cnt[i] = cnt[i] + 1;
      end
      ovM[i] = (ce ? 1'b0 : ovM[i]) | (we && !wAcc);
      unM[i] = (ce ? 1'b0 : unM[i]) | (re && !rAcc);
    end
  endtask

  task automatic checkInst(input int i, input logic [31:0] rd, input logic rv, input logic fl,
                           input logic em, input logic af, input logic ae, input logic ov,
                           input logic un, input logic [31:0] cntObs);
    string p;
    p = (i == 0) ? "d8" : "d5";
    checkOutput({p, ".count"}, cntObs, 32'(cnt[i]));
    checkOutput({p, ".full"}, 32'(fl), 32'(cnt[i] == depthM[i]));
    checkOutput({p, ".empty"}, 32'(em), 32'(cnt[i] == 0));
    checkOutput({p, ".almostFull"}, 32'(af), 32'(cnt[i] >= afM[i]));
    checkOutput({p, ".almostEmpty"}, 32'(ae), 32'(cnt[i] <= aeM[i]));
    checkOutput({p, ".overflow"}, 32'(ov), 32'(ovM[i]));
    checkOutput({p, ".underflow"}, 32'(un), 32'(unM[i]));
`ifdef FIFO_FLAGGED_FWFT_EN
    checkOutput({p, ".readValid"}, 32'(rv), 32'(cnt[i] > 0));
    if (cnt[i] > 0) begin
      checkOutput({p, ".readData"}, rd, store[i][head[i]]);
    end
`else
    checkOutput({p, ".readValid"}, 32'(rv), 32'(rvM[i]));
    checkOutput({p, ".readData"}, rd, rdM[i]);
`endif
  endtask

  task automatic checkAll();
    checkInst(0, rdA, rvA, fullA, emptyA, afA, aeA, ovA, unA, 32'(cntA));
    checkInst(1, rdB, rvB, fullB, emptyB, afB, aeB, ovB, unB, 32'(cntB));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare away from the edge.
  task automatic applyStimulus(input bit we, input logic [31:0] wd, input bit re, input bit ce);
    writeEn   = we;
    writeData = wd;
    readEn    = re;
    clearErr  = ce;
    @(posedge clk);
    #1;
    modelStep(we, wd, re, ce);
    writeEn  = 1'b0;
    readEn   = 1'b0;
    clearErr = 1'b0;
    checkAll();
  endtask

  initial begin
    depthM[0] = DA; afM[0] = AFA; aeM[0] = AEA;
    depthM[1] = DB; afM[1] = AFB; aeM[1] = AEB;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;

    $display("[TB] fill and drain in order");
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 32'h11 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] simultaneous read/write while full");
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 32'h21 + 32'(k), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAA, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] overflow and clear precedence");
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 32'h31 + 32'(k), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h9A, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] read and write on empty");
    applyStimulus(1'b1, 32'h5, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] pointer wrap with write/pop pairs");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end

    $display("[TB] asynchronous reset mid-sequence");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h40 + 32'(k), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkAll();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
